vec_mem_seq: RTL and testbench

- Vector load/store sequencer. Performs the memory access for VLD/VST once the ALU has produced the effective address (base + offset).
- Moves one 256-bit vector, as 16 lanes of 16 bits, over a word-wide data-memory port, one lane per accepted beat.
- Sits between the execute stage (ALU result and vector register read data) and data memory. Holds the pipeline stalled via `busy` until the transfer completes.

---
 rtl/vec_mem_seq_if.sv | 22 ++
 rtl/vec_mem_seq.sv | 122 ++++++++++++
 tb/tb_vec_mem_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_seq_if.sv
// Word-wide data-memory port between the vector load/store sequencer and memory.
interface vec_mem_seq_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata, mem_rdy
  );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves one LANES x WORD_W vector over a word-wide
// memory port, one lane per accepted beat, stalling the pipeline via busy.
module vec_mem_seq #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANES*WORD_W-1:0]   st_data,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*WORD_W-1:0]   ld_data,
  vec_mem_seq_if.master             mem
);

  localparam int unsigned VEC_W  = LANES * WORD_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, state_n;
  logic [LANE_W-1:0] lane, lane_n;
  logic              store_q, store_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [VEC_W-1:0]  st_q, st_n;
  logic [VEC_W-1:0]  ld_n;
  logic              busy_n, done_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rd_q, rd_n, wr_q, wr_n;
  logic [WORD_W-1:0] wdata_q, wdata_n;

  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd_en = rd_q;
  assign mem.mem_wr_en = wr_q;
  assign mem.mem_wdata = wdata_q;

  // State, lane and output registers; outputs are precomputed from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lane    <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      st_q    <= '0;
      ld_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      lane    <= lane_n;
      store_q <= store_n;
      base_q  <= base_n;
      st_q    <= st_n;
      ld_data <= ld_n;
      busy    <= busy_n;
      done    <= done_n;
      addr_q  <= addr_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      wdata_q <= wdata_n;
    end
  end

  // Next-state, lane bookkeeping and next-output logic.
  always_comb begin
    state_n = state;
    lane_n  = lane;
    store_n = store_q;
    base_n  = base_q;
    st_n    = st_q;
    ld_n    = ld_data;
    addr_n  = addr_q;
    wdata_n = wdata_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = XFER;
          lane_n  = '0;
          store_n = is_store;
          base_n  = base_addr;
          st_n    = st_data;
          // A load starts from a clean vector so untransferred lanes read 0.
          if (!is_store) ld_n = '0;
        end
      end
      XFER: begin
        if (mem.mem_rdy) begin
          if (!store_q) ld_n[lane*WORD_W +: WORD_W] = mem.mem_rdata;
          lane_n = lane + LANE_W'(1);
          if (lane == LANE_W'(LANES - 1)) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    rd_n   = (state_n == XFER) && !store_n;
    wr_n   = (state_n == XFER) && store_n;
    if (state_n == XFER) begin
      addr_n  = base_n + ADDR_W'(lane_n);
      wdata_n = st_n[lane_n*WORD_W +: WORD_W];
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: load, store, back-pressure, wrap, ignored start, reset abort.
module tb_vec_mem_seq;

  localparam int unsigned LANES  = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned VEC_W  = LANES * WORD_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [VEC_W-1:0]  st_data;
  logic              busy;
  logic              done;
  logic [VEC_W-1:0]  ld_data;

  logic              rdy;
  logic [ADDR_W-1:0] rd_base;
  logic [WORD_W-1:0] rd_pat;

  int n_cmp;
  int n_err;

  vec_mem_seq_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) mif ();

  vec_mem_seq #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .st_data   (st_data),
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .mem       (mif)
  );

  // Memory model: word at (rd_base + i) holds rd_pat + i; garbage when not ready.
  assign mif.mem_rdy   = rdy;
  assign mif.mem_rdata = rdy ? (rd_pat + (mif.mem_addr - rd_base)) : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_xfer(input logic st, input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] data);
    @(negedge clk);
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    st_data   = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, mif.mem_rd_en, mif.mem_wr_en});
    end
    n_cmp++;
    if (mif.mem_addr !== 16'h0000 || mif.mem_wdata !== 16'h0000) begin
      n_err++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/0000", mif.mem_addr, mif.mem_wdata);
    end
    n_cmp++;
    if (ld_data !== '0) begin
      n_err++; $display("FAIL reset_ld_data got=%h exp=0", ld_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_load(output logic [VEC_W-1:0] exp);
    for (int i = 0; i < 16; i++) exp[i*16 +: 16] = 16'h3C00 + 16'(i);
    rd_base = 16'h0100; rd_pat = 16'h3C00;
    start_xfer(1'b0, 16'h0100, '0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 16) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1010 || mif.mem_addr !== 16'h0100 + 16'(c - 1)) begin
          n_err++; $display("FAIL load_beat c=%0d got=%b/%h exp=1010/%h", c,
            {busy, done, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, 16'h0100 + 16'(c - 1));
        end
      end else if (c == 17) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1100) begin
          n_err++; $display("FAIL load_done got=%b exp=1100", {busy, done, mif.mem_rd_en, mif.mem_wr_en});
        end
        n_cmp++;
        if (ld_data[15:0] !== 16'h3C00 || ld_data[255:240] !== 16'h3C0F) begin
          n_err++; $display("FAIL load_lanes got=%h/%h exp=3c00/3c0f", ld_data[15:0], ld_data[255:240]);
        end
        n_cmp++;
        if (ld_data !== exp) begin
          n_err++; $display("FAIL load_vec got=%h exp=%h", ld_data, exp);
        end
      end else begin
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
          n_err++; $display("FAIL load_idle got=%b exp=00", {busy, done});
        end
      end
    end
  endtask

  task automatic test_store(input logic [VEC_W-1:0] prev_ld);
    logic [VEC_W-1:0] sv;
    logic rd_seen;
    rd_seen = 1'b0;
    for (int i = 0; i < 16; i++) sv[i*16 +: 16] = 16'hA000 + 16'(i);
    start_xfer(1'b1, 16'h2000, sv);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mif.mem_rd_en !== 1'b0) rd_seen = 1'b1;
      if (c <= 16) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1001 || mif.mem_addr !== 16'h2000 + 16'(c - 1)
            || mif.mem_wdata !== 16'hA000 + 16'(c - 1)) begin
          n_err++; $display("FAIL store_beat c=%0d got=%b/%h/%h exp=1001/%h/%h", c,
            {busy, done, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, mif.mem_wdata,
            16'h2000 + 16'(c - 1), 16'hA000 + 16'(c - 1));
        end
      end else if (c == 17) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1100) begin
          n_err++; $display("FAIL store_done got=%b exp=1100", {busy, done, mif.mem_rd_en, mif.mem_wr_en});
        end
      end
    end
    n_cmp++;
    if (rd_seen !== 1'b0) begin
      n_err++; $display("FAIL store_rd_en got=%b exp=0", rd_seen);
    end
    n_cmp++;
    if (ld_data !== prev_ld) begin
      n_err++; $display("FAIL store_ld_kept got=%h exp=%h", ld_data, prev_ld);
    end
  endtask

  task automatic test_back_pressure();
    logic [VEC_W-1:0] exp;
    int el;
    for (int i = 0; i < 16; i++) exp[i*16 +: 16] = 16'h5A00 + 16'(i);
    rd_base = 16'h0300; rd_pat = 16'h5A00;
    start_xfer(1'b0, 16'h0300, '0);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
      rdy = !(c >= 6 && c <= 8);
      el = (c <= 6) ? c - 1 : (c <= 9) ? 5 : c - 4;
      if (c <= 19) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1010 || mif.mem_addr !== 16'h0300 + 16'(el)) begin
          n_err++; $display("FAIL bp_beat c=%0d got=%b/%h exp=1010/%h", c,
            {busy, done, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, 16'h0300 + 16'(el));
        end
      end else if (c == 20) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1100 || ld_data !== exp) begin
          n_err++; $display("FAIL bp_done got=%b/%h exp=1100/%h", {busy, done, mif.mem_rd_en, mif.mem_wr_en}, ld_data, exp);
        end
      end else begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL bp_idle got=%b exp=0", busy);
        end
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_addr_wrap();
    logic [VEC_W-1:0] sv;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 16; i++) sv[i*16 +: 16] = 16'hB000 + 16'(i);
    start_xfer(1'b1, 16'hFFF8, sv);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'hFFF8 + 16'(c - 1);
      if (c <= 16) begin
        n_cmp++;
        if (mif.mem_wr_en !== 1'b1 || mif.mem_addr !== a || mif.mem_wdata !== 16'hB000 + 16'(c - 1)) begin
          n_err++; $display("FAIL wrap_beat c=%0d got=%b/%h/%h exp=1/%h/%h", c, mif.mem_wr_en,
            mif.mem_addr, mif.mem_wdata, a, 16'hB000 + 16'(c - 1));
        end
      end else if (c == 17) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_err++; $display("FAIL wrap_done got=%b exp=1", done);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [VEC_W-1:0] exp;
    int ndone;
    ndone = 0;
    for (int i = 0; i < 16; i++) exp[i*16 +: 16] = 16'h7700 + 16'(i);
    rd_base = 16'h0400; rd_pat = 16'h7700;
    start_xfer(1'b0, 16'h0400, '0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 5 || c == 17) begin
        start = 1'b1; is_store = 1'b1; base_addr = 16'h5555;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) ndone++;
      if (c <= 16) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b1010 || mif.mem_addr !== 16'h0400 + 16'(c - 1)) begin
          n_err++; $display("FAIL ign_beat c=%0d got=%b/%h exp=1010/%h", c,
            {busy, done, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, 16'h0400 + 16'(c - 1));
        end
      end else if (c >= 18) begin
        n_cmp++;
        if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b0000) begin
          n_err++; $display("FAIL ign_idle c=%0d got=%b exp=0000", c, {busy, done, mif.mem_rd_en, mif.mem_wr_en});
        end
      end
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++; $display("FAIL ign_done_count got=%0d exp=1", ndone);
    end
    n_cmp++;
    if (ld_data !== exp) begin
      n_err++; $display("FAIL ign_ld got=%h exp=%h", ld_data, exp);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [VEC_W-1:0] exp;
    rd_base = 16'h0100; rd_pat = 16'h3C00;
    start_xfer(1'b0, 16'h0100, '0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (mif.mem_addr !== 16'h0107) begin
      n_err++; $display("FAIL rst_pre_addr got=%h exp=0107", mif.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mif.mem_rd_en, mif.mem_wr_en} !== 4'b0000 || mif.mem_addr !== 16'h0000 || ld_data !== '0) begin
      n_err++; $display("FAIL rst_async got=%b/%h/%h exp=0000/0000/0",
        {busy, done, mif.mem_rd_en, mif.mem_wr_en}, mif.mem_addr, ld_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, mif.mem_rd_en} !== 3'b000) begin
        n_err++; $display("FAIL rst_hold c=%0d got=%b exp=000", c, {busy, done, mif.mem_rd_en});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp[i*16 +: 16] = 16'h1100 + 16'(i);
    rd_base = 16'h0800; rd_pat = 16'h1100;
    start_xfer(1'b0, 16'h0800, '0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 16) begin
        n_cmp++;
        if (mif.mem_addr !== 16'h080F || done !== 1'b0) begin
          n_err++; $display("FAIL rst_reload_last got=%h/%b exp=080f/0", mif.mem_addr, done);
        end
      end else if (c == 17) begin
        n_cmp++;
        if ({busy, done} !== 2'b11 || ld_data !== exp) begin
          n_err++; $display("FAIL rst_reload_done got=%b/%h exp=11/%h", {busy, done}, ld_data, exp);
        end
      end else if (c == 18) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL rst_reload_idle got=%b exp=0", busy);
        end
      end
    end
  endtask

  initial begin
    logic [VEC_W-1:0] load_vec;
    n_cmp = 0; n_err = 0;
    start = 1'b0; is_store = 1'b0; base_addr = '0; st_data = '0;
    rdy = 1'b1; rd_base = '0; rd_pat = '0;
    test_reset();
    test_load(load_vec);
    test_store(load_vec);
    test_back_pressure();
    test_addr_wrap();
    test_ignored_start();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
